// File: rtl/riscy_pkg.sv
// Shared types and constants for the riscy integer issue path.
package riscy_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE = 7'b0010011;
    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RS1,
        S_RS2,
        S_EXEC,
        S_WB
    } issue_state_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32 R/I-type ALU instruction decoder.
module alu_decode
    import riscy_pkg::*;
(
    input  logic [31:0]        instr,
    output alu_op_t            alu_op,
    output logic               is_rtype,
    output logic               is_itype,
    output logic               illegal,
    output logic [RADDR_W-1:0] rs1,
    output logic [RADDR_W-1:0] rs2,
    output logic [RADDR_W-1:0] rd,
    output logic [XLEN-1:0]    imm
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign rd     = instr[11:7];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    always_comb begin
        alu_op   = ALU_ADD;
        is_rtype = 1'b0;
        is_itype = 1'b0;
        illegal  = 1'b1;
        imm      = {{(XLEN-12){instr[31]}}, instr[31:20]};
        if (opcode == OPC_RTYPE) begin
            is_rtype = 1'b1;
            case (f3)
                3'd0: begin
                    alu_op  = (f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                    illegal = !(f7 == F7_BASE || f7 == F7_ALT);
                end
                3'd1: begin alu_op = ALU_SLL;  illegal = (f7 != F7_BASE); end
                3'd2: begin alu_op = ALU_SLT;  illegal = (f7 != F7_BASE); end
                3'd3: begin alu_op = ALU_SLTU; illegal = (f7 != F7_BASE); end
                3'd4: begin alu_op = ALU_XOR;  illegal = (f7 != F7_BASE); end
                3'd5: begin
                    alu_op  = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    illegal = !(f7 == F7_BASE || f7 == F7_ALT);
                end
                3'd6: begin alu_op = ALU_OR;   illegal = (f7 != F7_BASE); end
                3'd7: begin alu_op = ALU_AND;  illegal = (f7 != F7_BASE); end
                default: ;
            endcase
        end else if (opcode == OPC_ITYPE) begin
            is_itype = 1'b1;
            illegal  = 1'b0;
            case (f3)
                3'd0: alu_op = ALU_ADD;
                3'd2: alu_op = ALU_SLT;
                3'd3: alu_op = ALU_SLTU;
                3'd4: alu_op = ALU_XOR;
                3'd6: alu_op = ALU_OR;
                3'd7: alu_op = ALU_AND;
                3'd1: begin
                    alu_op  = ALU_SLL;
                    illegal = (f7 != F7_BASE);
                    imm     = {{(XLEN-5){1'b0}}, instr[24:20]};
                end
                3'd5: begin
                    alu_op  = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    illegal = !(f7 == F7_BASE || f7 == F7_ALT);
                    imm     = {{(XLEN-5){1'b0}}, instr[24:20]};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller: fetch operands over one RF port,
// drive the ALU, write back to rd.
module alu_issue_ctrl
    import riscy_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [31:0]        instr,
    output logic               instr_ready,
    output logic [RADDR_W-1:0] rf_raddr,
    input  logic [XLEN-1:0]    rf_rdata,
    output alu_op_t            alu_op,
    output logic [XLEN-1:0]    alu_a,
    output logic [XLEN-1:0]    alu_b,
    input  logic [XLEN-1:0]    alu_result,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]    rf_wdata,
    output logic               done,
    output logic               illegal
);

    issue_state_t       state;
    logic [31:0]        instr_q;
    logic [XLEN-1:0]    op_a;
    logic [XLEN-1:0]    op_b;
    logic [XLEN-1:0]    wdata;

    alu_op_t            dec_op;
    logic               dec_r;
    logic               dec_i;
    logic               dec_ill;
    logic [RADDR_W-1:0] dec_rs1;
    logic [RADDR_W-1:0] dec_rs2;
    logic [RADDR_W-1:0] dec_rd;
    logic [XLEN-1:0]    dec_imm;

    alu_decode u_dec (
        .instr    (instr_q),
        .alu_op   (dec_op),
        .is_rtype (dec_r),
        .is_itype (dec_i),
        .illegal  (dec_ill),
        .rs1      (dec_rs1),
        .rs2      (dec_rs2),
        .rd       (dec_rd),
        .imm      (dec_imm)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            instr_q <= '0;
            op_a    <= '0;
            op_b    <= '0;
            wdata   <= '0;
        end else begin
            case (state)
                S_IDLE: if (instr_valid) begin
                    instr_q <= instr;
                    state   <= S_RS1;
                end
                S_RS1: begin
                    op_a <= rf_rdata;
                    op_b <= dec_imm;
                    if (dec_ill)     state <= S_IDLE;
                    else if (dec_r)  state <= S_RS2;
                    else if (dec_i)  state <= S_EXEC;
                    else             state <= S_IDLE;
                end
                S_RS2: begin
                    op_b  <= rf_rdata;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    wdata <= alu_result;
                    state <= S_WB;
                end
                S_WB:    state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs are forced low while rst is high, including instr_ready.
    always_comb begin
        instr_ready = 1'b0;
        rf_raddr    = '0;
        alu_op      = ALU_ADD;
        alu_a       = '0;
        alu_b       = '0;
        rf_we       = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        done        = 1'b0;
        illegal     = 1'b0;
        if (!rst) begin
            case (state)
                S_IDLE: instr_ready = 1'b1;
                S_RS1: begin
                    if (dec_ill) illegal  = 1'b1;
                    else         rf_raddr = dec_rs1;
                end
                S_RS2: rf_raddr = dec_rs2;
                S_EXEC: begin
                    alu_op = dec_op;
                    alu_a  = op_a;
                    alu_b  = op_b;
                end
                S_WB: begin
                    rf_we    = (dec_rd != '0);
                    rf_waddr = dec_rd;
                    rf_wdata = wdata;
                    done     = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl.
module tb_alu_issue_ctrl;
    import riscy_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    alu_op_t     alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        done;
    logic        illegal;

    logic [31:0] rf [32];
    int          passed = 0;
    int          total = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .rf_raddr    (rf_raddr),
        .rf_rdata    (rf_rdata),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .done        (done),
        .illegal     (illegal)
    );

    assign rf_rdata = rf[rf_raddr];

    // Reference ALU standing in for the real datapath.
    always_comb begin
        case (alu_op)
            ALU_ADD:  alu_result = alu_a + alu_b;
            ALU_SUB:  alu_result = alu_a - alu_b;
            ALU_SLL:  alu_result = alu_a << alu_b[4:0];
            ALU_SLT:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU: alu_result = {31'd0, alu_a < alu_b};
            ALU_XOR:  alu_result = alu_a ^ alu_b;
            ALU_SRL:  alu_result = alu_a >> alu_b[4:0];
            ALU_SRA:  alu_result = $signed(alu_a) >>> alu_b[4:0];
            ALU_OR:   alu_result = alu_a | alu_b;
            ALU_AND:  alu_result = alu_a & alu_b;
            default:  alu_result = 32'd0;
        endcase
    end

    function automatic logic [31:0] r_word(input logic [6:0] f7,
        input logic [4:0] rs2, input logic [4:0] rs1,
        input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_word(input logic [11:0] imm,
        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a word, take the accept edge, return in cycle 1.
    task automatic issue(input logic [31:0] w);
        instr_valid = 1'b1;
        instr = w;
        step();
        instr_valid = 1'b0;
        instr = 32'hFFFF_FFFF;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        instr_valid = 1'b1;
        instr = r_word(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
        step();
        step();
        total++;
        if (instr_ready !== 1'b0)
            $display("FAIL rst_ready got %b exp 0", instr_ready);
        else passed++;
        total++;
        if ({rf_we, done, illegal, rf_raddr} !== 8'd0)
            $display("FAIL rst_outs got %h exp 0",
                {rf_we, done, illegal, rf_raddr});
        else passed++;
        instr_valid = 1'b0;
        rst = 1'b0;
        #1;
        total++;
        if (instr_ready !== 1'b1)
            $display("FAIL rst_release_ready got %b exp 1", instr_ready);
        else passed++;
        step();
    endtask

    task automatic test_add();
        rf[1] = 32'd4;
        rf[2] = 32'd6;
        issue(r_word(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
        total++;
        if (rf_raddr !== 5'd1 || instr_ready !== 1'b0)
            $display("FAIL add_rs1 got %0d/%b exp 1/0",
                rf_raddr, instr_ready);
        else passed++;
        step();
        total++;
        if (rf_raddr !== 5'd2)
            $display("FAIL add_rs2 got %0d exp 2", rf_raddr);
        else passed++;
        step();
        total++;
        if (alu_a !== 32'd4 || alu_b !== 32'd6 || alu_op !== ALU_ADD)
            $display("FAIL add_exec got %h %h %0d exp 4 6 0",
                alu_a, alu_b, alu_op);
        else passed++;
        step();
        total++;
        if (rf_we !== 1'b1 || done !== 1'b1 || rf_waddr !== 5'd3
            || rf_wdata !== 32'd10)
            $display("FAIL add_wb got we%b d%b a%0d %h exp 1 1 3 0000000a",
                rf_we, done, rf_waddr, rf_wdata);
        else passed++;
        step();
        total++;
        if (instr_ready !== 1'b1 || done !== 1'b0 || rf_we !== 1'b0)
            $display("FAIL add_after got r%b d%b w%b exp 1 0 0",
                instr_ready, done, rf_we);
        else passed++;
    endtask

    task automatic test_sub();
        rf[1] = 32'd4;
        rf[2] = 32'd6;
        issue(r_word(7'h20, 5'd2, 5'd1, 3'd0, 5'd3));
        repeat (3) step();
        total++;
        if (rf_we !== 1'b1 || rf_wdata !== 32'hFFFF_FFFE)
            $display("FAIL sub_neg got %b %h exp 1 fffffffe",
                rf_we, rf_wdata);
        else passed++;
        step();
        rf[1] = 32'hFFFF_FFFE;
        rf[2] = 32'hFFFF_FFFC;
        issue(r_word(7'h20, 5'd2, 5'd1, 3'd0, 5'd3));
        repeat (3) step();
        total++;
        if (rf_we !== 1'b1 || rf_wdata !== 32'd2)
            $display("FAIL sub_pos got %b %h exp 1 00000002",
                rf_we, rf_wdata);
        else passed++;
        step();
    endtask

    task automatic test_itype();
        rf[1] = 32'hFFFF_FFFE;
        issue(i_word(12'hFFC, 5'd1, 3'd0, 5'd5));
        step();
        total++;
        if (alu_b !== 32'hFFFF_FFFC || alu_a !== 32'hFFFF_FFFE)
            $display("FAIL addi_exec got %h %h exp fffffffe fffffffc",
                alu_a, alu_b);
        else passed++;
        step();
        total++;
        if (rf_we !== 1'b1 || done !== 1'b1 || rf_waddr !== 5'd5
            || rf_wdata !== 32'hFFFF_FFFA)
            $display("FAIL addi_wb got %b %b %0d %h exp 1 1 5 fffffffa",
                rf_we, done, rf_waddr, rf_wdata);
        else passed++;
        step();
        total++;
        if (instr_ready !== 1'b1)
            $display("FAIL addi_ready got %b exp 1", instr_ready);
        else passed++;
        rf[1] = 32'h8000_0000;
        issue(i_word(12'h401, 5'd1, 3'd5, 5'd5));
        step();
        total++;
        if (alu_b !== 32'd1 || alu_op !== ALU_SRA)
            $display("FAIL srai_exec got %h %0d exp 00000001 7",
                alu_b, alu_op);
        else passed++;
        step();
        total++;
        if (rf_we !== 1'b1 || rf_wdata !== 32'hC000_0000)
            $display("FAIL srai_wb got %b %h exp 1 c0000000",
                rf_we, rf_wdata);
        else passed++;
        step();
    endtask

    task automatic test_illegal();
        logic [31:0] bad [3];
        bad[0] = {20'h12345, 5'd3, 7'b0110111};
        bad[1] = r_word(7'h01, 5'd2, 5'd1, 3'd0, 5'd3);
        bad[2] = i_word(12'h401, 5'd1, 3'd1, 5'd3);
        for (int i = 0; i < 3; i++) begin
            issue(bad[i]);
            total++;
            if (illegal !== 1'b1 || rf_we !== 1'b0 || rf_raddr !== 5'd0)
                $display("FAIL illegal_pulse[%0d] got %b %b %0d exp 1 0 0",
                    i, illegal, rf_we, rf_raddr);
            else passed++;
            step();
            total++;
            if (instr_ready !== 1'b1 || illegal !== 1'b0 || rf_we !== 1'b0)
                $display("FAIL illegal_ready[%0d] got %b %b %b exp 1 0 0",
                    i, instr_ready, illegal, rf_we);
            else passed++;
        end
    endtask

    task automatic test_rd0();
        rf[1] = 32'd4;
        rf[2] = 32'd6;
        issue(r_word(7'h00, 5'd2, 5'd1, 3'd0, 5'd0));
        repeat (3) step();
        total++;
        if (done !== 1'b1 || rf_we !== 1'b0)
            $display("FAIL rd0_wb got done %b we %b exp 1 0", done, rf_we);
        else passed++;
        step();
    endtask

    task automatic test_back_to_back();
        rf[1] = 32'd4;
        rf[2] = 32'd6;
        instr_valid = 1'b1;
        instr = r_word(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
        step();
        instr = i_word(12'h001, 5'd2, 3'd0, 5'd6);
        repeat (3) step();
        total++;
        if (rf_wdata !== 32'd10 || instr_ready !== 1'b0)
            $display("FAIL b2b_first got %h r%b exp 0000000a 0",
                rf_wdata, instr_ready);
        else passed++;
        step();
        total++;
        if (instr_ready !== 1'b1)
            $display("FAIL b2b_ready5 got %b exp 1", instr_ready);
        else passed++;
        step();
        instr_valid = 1'b0;
        total++;
        if (rf_raddr !== 5'd2 || instr_ready !== 1'b0)
            $display("FAIL b2b_accept got %0d r%b exp 2 0",
                rf_raddr, instr_ready);
        else passed++;
        repeat (2) step();
        total++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 32'd7)
            $display("FAIL b2b_second got %b %0d %h exp 1 6 00000007",
                rf_we, rf_waddr, rf_wdata);
        else passed++;
        step();
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        rf[1] = 32'd4;
        rf[2] = 32'd6;
        issue(r_word(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
        repeat (2) step();
        rst = 1'b1;
        #1;
        total++;
        if (alu_a !== 32'd0 || alu_b !== 32'd0 || instr_ready !== 1'b0)
            $display("FAIL rstmid_outs got %h %h r%b exp 0 0 0",
                alu_a, alu_b, instr_ready);
        else passed++;
        step();
        rst = 1'b0;
        #1;
        total++;
        if (instr_ready !== 1'b1)
            $display("FAIL rstmid_ready got %b exp 1", instr_ready);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            if (rf_we === 1'b1 || done === 1'b1) seen++;
            step();
        end
        total++;
        if (seen !== 0)
            $display("FAIL rstmid_nowb got %0d exp 0", seen);
        else passed++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        rst = 1'b1;
        instr_valid = 1'b0;
        instr = 32'd0;
        test_reset();
        test_add();
        test_sub();
        test_itype();
        test_illegal();
        test_rd0();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Multi-cycle issue controller that sequences the R-type/I-type integer ALU of the riscy core. It accepts one 32-bit instruction word per handshake and decodes opcode/funct3/funct7. It fetches rs1 (and rs2 for R-type) through a single shared register-file read port, drives the ALU, and writes the result back to rd. It sits between the fetch stage and the register file/ALU pair and is the only block that drives ALU operands.

## Interface
- XLEN, 32, datapath width
- RADDR_W, 5, register address width (32 architectural registers)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- instr_valid  in  1  instruction word offered
- instr  in  32  RV32 instruction word
- instr_ready  out  1  controller can accept (IDLE only)
- rf_raddr  out  RADDR_W  shared read-port address
- rf_rdata  in  XLEN  read data, combinational from rf_raddr
- alu_op  out  4  alu_op_t encoding
- alu_a, alu_b  out  XLEN  ALU operands
- alu_result  in  XLEN  combinational ALU result
- rf_we  out  1  write enable, one-cycle pulse
- rf_waddr  out  RADDR_W  write address
- rf_wdata  out  XLEN  write data
- done  out  1  one-cycle pulse, instruction retired
- illegal  out  1  one-cycle pulse, instruction rejected

## Operation
- FSM states: IDLE, RS1, RS2, EXEC, WB.
- IDLE: instr_ready=1. On instr_valid&&instr_ready, latch instr, decode, go to RS1.
- RS1:
  - illegal decode: pulse illegal, go to IDLE, no read, no write.
  - otherwise rf_raddr=rs1 and capture rf_rdata into opA.
  - R-type goes to RS2. I-type captures sign-extended imm[11:0] into opB and goes to EXEC.
- RS2: rf_raddr=rs2, capture into opB, go to EXEC.
- EXEC: alu_a=opA, alu_b=opB, alu_op=decoded op. Capture alu_result into wdata register, go to WB.
- WB: rf_we=1 unless rd==0, rf_waddr=rd, rf_wdata=wdata. done=1, go to IDLE.
- R-type decode, opcode 0110011, by funct3/funct7:
  - 0/00 ADD, 0/20 SUB, 1/00 SLL, 2/00 SLT, 3/00 SLTU, 4/00 XOR
  - 5/00 SRL, 5/20 SRA, 6/00 OR, 7/00 AND
- I-type decode, opcode 0010011:
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI use any imm.
  - SLLI needs imm[11:5]=00. SRLI needs imm[11:5]=00, SRAI needs imm[11:5]=20. For shifts, opB = zero-extended shamt.
- Illegal: any other opcode, or any funct7/imm[11:5] combination not listed.
- Outside its state: rf_raddr=0, alu_a=alu_b=0, alu_op=ADD. rf_we/done/illegal are 0 outside their cycle.
- All arithmetic is XLEN-bit, wrap-around. SLT/SLTU write 0 or 1. Shifts use operand bits [4:0] only.

## Timing
- Reset: while rst=1 and in the cycle it is sampled, the FSM goes to IDLE and all outputs are 0, including instr_ready. instr_ready=1 from the first cycle after rst deasserts.
- Reset mid-operation aborts the instruction: no rf_we, no done, latched instr discarded.
- Accept edge = cycle 0.
  - R-type: done/rf_we at cycle 4, instr_ready at cycle 5.
  - I-type: done/rf_we at cycle 3.
  - Illegal: illegal at cycle 1, instr_ready at cycle 2.
- Throughput: one instruction per 5 cycles (R-type) or 4 cycles (I-type). instr_valid held high is accepted on each IDLE cycle.
- instr is sampled only on the accept edge. Changes afterwards are ignored.
- rd==0: done pulses, rf_we stays 0.

## Structure
- riscy_pkg holds:
  - OPC_RTYPE=7'b0110011 and OPC_ITYPE=7'b0010011
  - funct7 constants F7_BASE=7'h00, F7_ALT=7'h20
  - alu_op_t enum (ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND)
  - issue_state_t enum
- Sub-module alu_decode: combinational, instr → {alu_op, is_rtype, is_itype, illegal, rs1, rs2, rd, imm}. The same decoder is reused by later pipeline stages.

## Test plan
- R-type ADD x3,x1,x2 with x1=4, x2=6 → rf_we at cycle 4, rf_waddr=3, rf_wdata=10, done=1.
- R-type SUB (f7=20), x1=4, x2=6 → rf_wdata=0xFFFFFFFE. Then x1=-2, x2=-4 → rf_wdata=2.
- ADDI x5,x1,-4 with x1=-2 → rf_wdata=0xFFFFFFFA at cycle 3. SRAI x5,x1,1 with x1=0x80000000 → 0xC0000000.
- Illegal inputs → illegal pulse at cycle 1, no rf_we, instr_ready back at cycle 2:
  - opcode 0110111
  - R-type f3=0, f7=0x01
- ADD x0,x1,x2 → done at cycle 4 with rf_we=0. Back-to-back instr_valid held high → second accept exactly at cycle 5.
- rst asserted in EXEC of an ADD → no rf_we/done ever for it. IDLE with instr_ready=1 one cycle after rst drops.
